seq_phasor_scheduler: RTL and testbench
=======================================

Name: seq_phasor_scheduler

Overview:
Sequences the sequence decomposer's amplitude/phase estimation.
- Generates the decimated sample strobe and the 8-bit sample index k from the fast system clock.
- At each analysis-window wrap, shares one phasor-estimation engine (CORDIC/DFT) among the three sequence channels (zero, pos, neg), strictly in the order zero → pos → neg.
- Sits between the sample front end and the shared engine.
- Publishes one tagged result per channel per window.

Parameters:
- DECIM, 2: system clocks per sample strobe (≥2).
- N_SAMPLES, 200: samples per analysis window; k wraps at N_SAMPLES-1 (≤ 2^KW).
- KW, 8: width of k.
- AW, 14: amplitude width (unsigned).
- PW, 16: phase width (unsigned, full-scale = 360°).
- TIMEOUT, 255: engine watchdog limit in clocks (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  run enable for the sample timer.
- clr_overrun  in  1  clears the sticky overrun flag.
- sample_stb  out  1  one-clock pulse per sample.
- k  out  KW  current sample index.
- win_done  out  1  one-clock pulse when k wraps.
- eng_start  out  1  one-clock start pulse to the engine.
- eng_sel  out  2  channel select: 0 = zero, 1 = pos, 2 = neg.
- eng_done  in  1  engine result-valid pulse.
- eng_amp  in  AW  engine amplitude.
- eng_phase  in  PW  engine phase.
- res_valid  out  1  one-clock result pulse.
- res_sel  out  2  channel tag of the result.
- res_amp  out  AW  latched amplitude.
- res_phase  out  PW  latched phase.
- res_err  out  1  result was produced by timeout.
- busy  out  1  FSM not in IDLE.
- overrun  out  1  sticky flag: window dropped.

Behaviour:
- Reset (async, rst=1):
  - Decimation counter = 0; k = 0.
  - FSM = IDLE; channel = 0.
  - All outputs = 0.
- Sample timer:
  - Decimation counter counts 0..DECIM-1 while en=1.
  - sample_stb is a registered pulse in the clock after the counter reaches DECIM-1. The first pulse comes DECIM clocks after en rises.
  - k increments on sample_stb and wraps from N_SAMPLES-1 to 0.
  - win_done pulses in the same cycle k is updated to 0 by a wrap.
  - en=0: counter and k hold, no strobes. The FSM still finishes any pass in progress.
- FSM states: IDLE, ISSUE, WAIT, STORE.
  - IDLE: win_done=1 → channel := 0, go to ISSUE.
  - ISSUE: eng_start=1 for exactly this cycle; eng_sel = channel → WAIT. eng_done in this cycle is ignored.
  - WAIT: eng_done=1 → latch eng_amp/eng_phase into res_amp/res_phase → STORE.
  - STORE: res_valid=1, res_sel=channel, res_err=0.
    - channel==2 → IDLE.
    - Otherwise channel+1 → ISSUE.
- Stability: eng_sel is stable from ISSUE through STORE. res_amp, res_phase and res_sel hold until the next STORE.
- busy = (state != IDLE).
- Latency with an engine that returns eng_done one cycle after start, win_done at cycle t:
  - eng_start at t+1, t+4, t+7.
  - res_valid at t+3, t+6, t+9.
- Overrun:
  - win_done while the FSM is not in IDLE sets overrun=1 and that window is dropped.
  - This includes win_done in the STORE cycle of channel 2.
  - clr_overrun clears the flag. If clr_overrun and a new overrun occur in the same cycle, set wins.
- Reset mid-pass: immediate return to IDLE with all outputs 0. There is no resumption; the engine must tolerate an abandoned start.

Optional Feature:
SEQ_SCHED_TIMEOUT_EN
- Defined: a WAIT-cycle counter is active.
  - If TIMEOUT cycles pass in WAIT without eng_done, go to STORE with res_err=1 and res_amp=0, res_phase=0.
  - The pass then continues with the next channel.
  - The counter is cleared on every entry to ISSUE.
- Undefined: WAIT blocks indefinitely, res_err is tied to 0, and no counter logic is built.

Decomposition:
- Package seq_sched_pkg holds:
  - Channel codes CH_ZERO=0, CH_POS=1, CH_NEG=2.
  - FSM state encoding.
  - Default widths AW=14, PW=16, KW=8.
- One sub-module, seq_sample_timer (decimation counter, k counter, win_done). It is instantiated once.
- FSM, result latch and flags stay in the top module.

Test Plan:
- DECIM=2, N_SAMPLES=8, en=1 after reset → sample_stb every 2 clocks; k runs 0..7,0; win_done coincides with k=0 every 16 clocks.
- Engine model with 1-clock latency returning amp=1000/2000/3000, phase=0x1000/0x2000/0x3000 → res_valid at t+3, t+6, t+9 with res_sel 0, 1, 2 and the matching values; eng_start exactly 3 pulses.
- Engine latency 20 clocks, N_SAMPLES=8, DECIM=2 → second win_done arrives mid-pass; overrun=1; that window yields no results; clr_overrun → 0.
- en dropped for 10 clocks at k=5 → k holds at 5, no sample_stb; resumes at 6 two clocks after en=1.
- SEQ_SCHED_TIMEOUT_EN, TIMEOUT=16, engine never responds on channel 1 → channel-1 result has res_err=1, amp=0 at 16 clocks after entering WAIT; channel 2 is still issued.
- rst pulsed during WAIT of channel 1 → all outputs 0 and busy=0 asynchronously; next win_done restarts at channel 0.

Source files
------------

// File: rtl/seq_phasor_scheduler_pkg.sv
// Shared types and constants for the sequence phasor scheduler.
// Channel codes, FSM state encoding and default datapath widths.
package seq_sched_pkg;

    localparam int unsigned DEFAULT_AW = 14;
    localparam int unsigned DEFAULT_PW = 16;
    localparam int unsigned DEFAULT_KW = 8;

    typedef logic [1:0] ch_t;

    localparam ch_t CH_ZERO = 2'd0;
    localparam ch_t CH_POS  = 2'd1;
    localparam ch_t CH_NEG  = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StStore
    } state_e;

endpackage

// File: rtl/seq_phasor_scheduler_if.sv
// Engine handshake and tagged-result bus between the scheduler and the shared
// phasor engine / result consumer.
interface seq_phasor_scheduler_if
    import seq_sched_pkg::*;
#(
    parameter int unsigned AW = DEFAULT_AW,
    parameter int unsigned PW = DEFAULT_PW
);
    logic          eng_start;
    ch_t           eng_sel;
    logic          eng_done;
    logic [AW-1:0] eng_amp;
    logic [PW-1:0] eng_phase;

    logic          res_valid;
    ch_t           res_sel;
    logic [AW-1:0] res_amp;
    logic [PW-1:0] res_phase;
    logic          res_err;

    modport master (
        output eng_start, eng_sel,
        input  eng_done, eng_amp, eng_phase,
        output res_valid, res_sel, res_amp, res_phase, res_err
    );

    modport slave (
        input  eng_start, eng_sel,
        output eng_done, eng_amp, eng_phase,
        input  res_valid, res_sel, res_amp, res_phase, res_err
    );
endinterface

// File: rtl/seq_phasor_scheduler_sample_timer.sv
// Decimated sample strobe, sample index k and window-wrap pulse.
// k and win_done update on the same edge that raises sample_stb.
module seq_sample_timer #(
    parameter int unsigned DECIM     = 2,
    parameter int unsigned N_SAMPLES = 200,
    parameter int unsigned KW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          sample_stb,
    output logic [KW-1:0] k,
    output logic          win_done
);
    localparam int unsigned CW = (DECIM > 2) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] CntLast = CW'(DECIM - 1);
    localparam logic [KW-1:0] KLast   = KW'(N_SAMPLES - 1);

    logic [CW-1:0] cnt_q;
    logic [KW-1:0] k_q;
    logic          stb_q;
    logic          win_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            k_q   <= '0;
            stb_q <= 1'b0;
            win_q <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            win_q <= 1'b0;
            if (en) begin
                if (cnt_q == CntLast) begin
                    cnt_q <= '0;
                    stb_q <= 1'b1;
                    if (k_q == KLast) begin
                        k_q   <= '0;
                        win_q <= 1'b1;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign sample_stb = stb_q;
    assign k          = k_q;
    assign win_done   = win_q;
endmodule

// File: rtl/seq_phasor_scheduler.sv
// Shares one phasor engine among the zero/pos/neg channels once per window.
// Optional engine watchdog: define SEQ_SCHED_TIMEOUT_EN.
module seq_phasor_scheduler
    import seq_sched_pkg::*;
#(
    parameter int unsigned DECIM     = 2,
    parameter int unsigned N_SAMPLES = 200,
    parameter int unsigned KW        = DEFAULT_KW,
    parameter int unsigned AW        = DEFAULT_AW,
    parameter int unsigned PW        = DEFAULT_PW,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr_overrun,
    output logic                    sample_stb,
    output logic [KW-1:0]           k,
    output logic                    win_done,
    output logic                    busy,
    output logic                    overrun,
    seq_phasor_scheduler_if.master  eng_bus
);
    state_e        state_q;
    ch_t           ch_q;
    logic          eng_start_q;
    ch_t           eng_sel_q;
    logic          res_valid_q;
    ch_t           res_sel_q;
    logic [AW-1:0] res_amp_q;
    logic [PW-1:0] res_phase_q;
    logic          overrun_q;

    seq_sample_timer #(
        .DECIM     (DECIM),
        .N_SAMPLES (N_SAMPLES),
        .KW        (KW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sample_stb (sample_stb),
        .k          (k),
        .win_done   (win_done)
    );

`ifdef SEQ_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q;
    logic          res_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ch_q        <= CH_ZERO;
            eng_start_q <= 1'b0;
            eng_sel_q   <= CH_ZERO;
            res_valid_q <= 1'b0;
            res_sel_q   <= CH_ZERO;
            res_amp_q   <= '0;
            res_phase_q <= '0;
            overrun_q   <= 1'b0;
`ifdef SEQ_SCHED_TIMEOUT_EN
            wait_cnt_q  <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            eng_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            // A window arriving mid-pass is dropped; setting beats clearing.
            if (win_done && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (win_done) begin
                        ch_q        <= CH_ZERO;
                        eng_sel_q   <= CH_ZERO;
                        eng_start_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
`ifdef SEQ_SCHED_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    if (eng_bus.eng_done) begin
                        res_amp_q   <= eng_bus.eng_amp;
                        res_phase_q <= eng_bus.eng_phase;
                        res_sel_q   <= ch_q;
                        res_valid_q <= 1'b1;
                        state_q     <= StStore;
`ifdef SEQ_SCHED_TIMEOUT_EN
                        res_err_q   <= 1'b0;
                    end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                        res_amp_q   <= '0;
                        res_phase_q <= '0;
                        res_sel_q   <= ch_q;
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b1;
                        state_q     <= StStore;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
`endif
                    end
                end
                StStore: begin
                    if (ch_q == CH_NEG) begin
                        state_q <= StIdle;
                    end else begin
                        ch_q        <= ch_q + 2'd1;
                        eng_sel_q   <= ch_q + 2'd1;
                        eng_start_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign eng_bus.eng_start = eng_start_q;
    assign eng_bus.eng_sel   = eng_sel_q;
    assign eng_bus.res_valid = res_valid_q;
    assign eng_bus.res_sel   = res_sel_q;
    assign eng_bus.res_amp   = res_amp_q;
    assign eng_bus.res_phase = res_phase_q;
`ifdef SEQ_SCHED_TIMEOUT_EN
    assign eng_bus.res_err   = res_err_q;
`else
    assign eng_bus.res_err   = 1'b0;
`endif
    assign busy    = (state_q != StIdle);
    assign overrun = overrun_q;
endmodule

// File: tb/tb_seq_phasor_scheduler.sv
// Directed, table-driven bench for seq_phasor_scheduler (DECIM=2, N_SAMPLES=8).
// Timeout checks run only when SEQ_SCHED_TIMEOUT_EN is defined.
module tb_seq_phasor_scheduler;
    logic       clk = 1'b0;
    logic       rst, en, clr;
    logic       sample_stb, win_done, busy, overrun;
    logic [7:0] k;
    int         nvec = 0;
    int         nmis = 0;
    int         cyc  = 0;

    seq_phasor_scheduler_if #(.AW(14), .PW(16)) bus ();

    seq_phasor_scheduler #(
        .DECIM(2), .N_SAMPLES(8), .KW(8), .AW(14), .PW(16), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr_overrun(clr),
        .sample_stb(sample_stb), .k(k), .win_done(win_done),
        .busy(busy), .overrun(overrun), .eng_bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [1:0] sel;} start_t;
    typedef struct {int cyc; logic [1:0] sel; logic [13:0] amp; logic [15:0] ph; logic err;} res_t;
    start_t start_q[$];
    res_t   res_q[$];
    int     win_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (win_done) win_q.push_back(cyc);
            if (bus.eng_start) start_q.push_back('{cyc, bus.eng_sel});
            if (bus.res_valid)
                res_q.push_back('{cyc, bus.res_sel, bus.res_amp, bus.res_phase, bus.res_err});
        end
    end

    // Engine model: answers eng_lat clocks after a start, except for silent_ch.
    int         eng_lat   = 1;
    int         pend      = 0;
    int         silent_ch = 3;
    logic [1:0] pend_sel  = 2'd0;
    initial begin
        bus.eng_done = 1'b0; bus.eng_amp = '0; bus.eng_phase = '0;
        forever begin
            @(posedge clk); #1;
            bus.eng_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.eng_done  = 1'b1;
                    bus.eng_amp   = 14'(1000 * (int'(pend_sel) + 1));
                    bus.eng_phase = 16'(32'h1000 * (int'(pend_sel) + 1));
                end
            end
            if (bus.eng_start && int'(bus.eng_sel) != silent_ch) begin
                pend     = eng_lat;
                pend_sel = bus.eng_sel;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {15'b0, sample_stb, k, win_done, bus.eng_start, bus.eng_sel, bus.res_valid,
                bus.res_sel, bus.res_amp, bus.res_phase, bus.res_err, busy, overrun};
    endfunction

    task automatic clear_q();
        start_q.delete(); res_q.delete(); win_q.delete();
    endtask

    task automatic wait_for_win();
        int n = 0;
        do begin @(negedge clk); n++; end while (!win_done && n < 200);
        chk("win_done_seen", win_done, 1'b1);
    endtask

    task automatic wait_for_start(input logic [1:0] sel);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(bus.eng_start && bus.eng_sel == sel) && n < 200);
        chk("eng_start_seen", {bus.eng_start, bus.eng_sel}, {1'b1, sel});
    endtask

    typedef struct {int st_off; int res_off; logic [1:0] sel; logic [13:0] amp; logic [15:0] ph;} pass_t;
    pass_t pv[3];

    task automatic check_pass(input bit timing);
        chk("start_count", start_q.size(), 3);
        chk("res_count", res_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < start_q.size() && i < res_q.size() && win_q.size() > 0) begin
                if (timing) begin
                    chk("start_offset", start_q[i].cyc - win_q[0], pv[i].st_off);
                    chk("res_offset", res_q[i].cyc - win_q[0], pv[i].res_off);
                end
                chk("eng_sel", start_q[i].sel, pv[i].sel);
                chk("res_sel", res_q[i].sel, pv[i].sel);
                chk("res_amp", res_q[i].amp, pv[i].amp);
                chk("res_phase", res_q[i].ph, pv[i].ph);
                chk("res_err", res_q[i].err, 1'b0);
            end
        end
    endtask

    typedef struct {logic stb; logic [7:0] k; logic win; logic busy;} tvec_t;
    tvec_t tv[18];

    initial begin
        tv[0]  = '{0, 0, 0, 0}; tv[1]  = '{1, 1, 0, 0}; tv[2]  = '{0, 1, 0, 0};
        tv[3]  = '{1, 2, 0, 0}; tv[4]  = '{0, 2, 0, 0}; tv[5]  = '{1, 3, 0, 0};
        tv[6]  = '{0, 3, 0, 0}; tv[7]  = '{1, 4, 0, 0}; tv[8]  = '{0, 4, 0, 0};
        tv[9]  = '{1, 5, 0, 0}; tv[10] = '{0, 5, 0, 0}; tv[11] = '{1, 6, 0, 0};
        tv[12] = '{0, 6, 0, 0}; tv[13] = '{1, 7, 0, 0}; tv[14] = '{0, 7, 0, 0};
        tv[15] = '{1, 0, 1, 0}; tv[16] = '{0, 0, 0, 1}; tv[17] = '{1, 1, 0, 1};
        pv[0] = '{1, 3, 2'd0, 14'd1000, 16'h1000};
        pv[1] = '{4, 6, 2'd1, 14'd2000, 16'h2000};
        pv[2] = '{7, 9, 2'd2, 14'd3000, 16'h3000};

        rst = 1'b1; en = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'h0);

        // Sample timer from en rising, first window and its pass.
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk("timer_vec", {sample_stb, k, win_done, busy},
                {tv[i].stb, tv[i].k, tv[i].win, tv[i].busy});
        end
        repeat (10) @(negedge clk);
        check_pass(1'b1);
        chk("idle_after_pass", {busy, overrun}, 2'b00);

        // Slow engine: windows arriving mid-pass are dropped.
        eng_lat = 20;
        clear_q();
        wait_for_win();
        repeat (72) @(negedge clk);
        chk("overrun_set", overrun, 1'b1);
        chk("win_count", win_q.size(), 5);
        check_pass(1'b0);
        chk("idle_after_slow", busy, 1'b0);
        en = 1'b0;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("overrun_cleared", overrun, 1'b0);

        // en dropped at k=5.
        eng_lat = 1;
        en = 1'b1;
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!(sample_stb && k == 8'd5) && n < 40);
        end
        chk("reach_k5", {sample_stb, k}, {1'b1, 8'd5});
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("en_low_hold", {sample_stb, k}, {1'b0, 8'd5});
        end
        en = 1'b1;
        @(negedge clk); chk("resume_1", {sample_stb, k}, {1'b0, 8'd5});
        @(negedge clk); chk("resume_2", {sample_stb, k}, {1'b1, 8'd6});

        // Reset during WAIT of channel 1, then a clean restart.
        eng_lat = 20;
        clear_q();
        wait_for_win();
        wait_for_start(2'd1);
        repeat (3) @(negedge clk);
        chk("busy_in_wait", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", outs(), 64'h0);
        pend = 0;
        @(negedge clk);
        rst = 1'b0; eng_lat = 1;
        clear_q();
        wait_for_win();
        repeat (12) @(negedge clk);
        check_pass(1'b1);

`ifdef SEQ_SCHED_TIMEOUT_EN
        // Engine silent on channel 1: watchdog result, then channel 2 proceeds.
        silent_ch = 1;
        clear_q();
        wait_for_win();
        repeat (26) @(negedge clk);
        chk("to_res_count", res_q.size(), 3);
        chk("to_start_count", start_q.size(), 3);
        if (res_q.size() == 3 && start_q.size() == 3 && win_q.size() > 0) begin
            chk("to_res1_offset", res_q[1].cyc - win_q[0], 21);
            chk("to_res1", {res_q[1].sel, res_q[1].err, res_q[1].amp, res_q[1].ph},
                {2'd1, 1'b1, 14'd0, 16'd0});
            chk("to_start2", {start_q[2].sel, 32'(start_q[2].cyc - win_q[0])}, {2'd2, 32'd22});
            chk("to_res2", {res_q[2].sel, res_q[2].err, res_q[2].amp}, {2'd2, 1'b0, 14'd3000});
        end
        silent_ch = 3;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
